// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the decode-side hazard scoreboard:
// URA encodings, forwarding select codes and mult/div kind encodings.
package hazard_scoreboard_pkg;

    localparam int URA_BITS   = 7;
    localparam int NUM_STAGES = 3;

    localparam logic [URA_BITS-1:0] URA_NONE = 7'b0000000;
    localparam logic [URA_BITS-1:0] URA_HI   = 7'b1000000;
    localparam logic [URA_BITS-1:0] URA_LO   = 7'b1000001;
    localparam logic [URA_BITS-1:0] URA_RA   = 7'b0011111;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_RSVD = 2'b11
    } md_kind_e;

    // URA 0 means "no register" and must never produce a match.
    function automatic logic ura_hit(input logic [URA_BITS-1:0] src,
                                     input logic [URA_BITS-1:0] a,
                                     input logic [URA_BITS-1:0] b);
        return (src != URA_NONE) && ((src == a) || (src == b));
    endfunction

endpackage

// File: rtl/hazard_scoreboard_stage_reg.sv
// One in-flight slot (E, M or W): captures the upstream destination URAs and
// Tnew, optionally decrementing Tnew, or becomes a bubble on no-load/flush.
module hazard_stage_reg
    import hazard_scoreboard_pkg::*;
#(
    parameter int URA_W    = 7,
    parameter bit DEC_TNEW = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [URA_W-1:0] ura_a_i,
    input  logic [URA_W-1:0] ura_b_i,
    input  logic [1:0]       tnew_i,
    output logic [URA_W-1:0] ura_a_o,
    output logic [URA_W-1:0] ura_b_o,
    output logic [1:0]       tnew_o
);

    logic [URA_W-1:0] ura_a_q, ura_a_d;
    logic [URA_W-1:0] ura_b_q, ura_b_d;
    logic [1:0]       tnew_q, tnew_d;

    always_comb begin
        ura_a_d = '0;
        ura_b_d = '0;
        tnew_d  = '0;
        if (load_i && !flush_i) begin
            ura_a_d = ura_a_i;
            ura_b_d = ura_b_i;
            // Saturating countdown so a ready result stays ready.
            if (DEC_TNEW && (tnew_i != 2'd0)) begin
                tnew_d = tnew_i - 2'd1;
            end else begin
                tnew_d = tnew_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ura_a_q <= '0;
            ura_b_q <= '0;
            tnew_q  <= '0;
        end else begin
            ura_a_q <= ura_a_d;
            ura_b_q <= ura_b_d;
            tnew_q  <= tnew_d;
        end
    end

    assign ura_a_o = ura_a_q;
    assign ura_b_o = ura_b_q;
    assign tnew_o  = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard controller: tracks destinations through E/M/W plus a
// mult/div busy counter, and produces the D stall and forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int URA_W       = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d_valid,
    input  logic [URA_W-1:0] d_ura_real,
    input  logic [URA_W-1:0] d_ura_possible1,
    input  logic [1:0]       d_tnew,
    input  logic [URA_W-1:0] d_rs_ura,
    input  logic [1:0]       d_rs_tuse,
    input  logic [URA_W-1:0] d_rt_ura,
    input  logic [1:0]       d_rt_tuse,
    input  logic [1:0]       d_md_kind,
    input  logic             d_uses_hilo,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic             md_busy
);

    logic [URA_W-1:0] st_a    [NUM_STAGES];
    logic [URA_W-1:0] st_b    [NUM_STAGES];
    logic [1:0]       st_tnew [NUM_STAGES];

    logic [URA_W-1:0] src_ura  [2];
    logic [1:0]       src_tuse [2];

    logic       e_load;
    logic       md_load;
    logic [3:0] md_cnt_q, md_cnt_d;

    assign src_ura[0]  = d_rs_ura;
    assign src_ura[1]  = d_rt_ura;
    assign src_tuse[0] = d_rs_tuse;
    assign src_tuse[1] = d_rt_tuse;

    assign e_load = d_valid && !stall && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            logic [URA_W-1:0] in_a, in_b;
            logic [1:0]       in_tnew;
            logic             in_load;

            if (gi == 0) begin : g_from_d
                assign in_a    = d_ura_real;
                assign in_b    = d_ura_possible1;
                assign in_tnew = d_tnew;
                assign in_load = e_load;
            end else begin : g_from_prev
                assign in_a    = st_a[gi-1];
                assign in_b    = st_b[gi-1];
                assign in_tnew = st_tnew[gi-1];
                assign in_load = 1'b1;
            end

            // Only the E->M hop counts Tnew down; W is a straight copy of M.
            hazard_stage_reg #(
                .URA_W   (URA_W),
                .DEC_TNEW(gi == 1)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .flush_i (flush),
                .load_i  (in_load),
                .ura_a_i (in_a),
                .ura_b_i (in_b),
                .tnew_i  (in_tnew),
                .ura_a_o (st_a[gi]),
                .ura_b_o (st_b[gi]),
                .tnew_o  (st_tnew[gi])
            );
        end

        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [1:0] hit_stage;
            logic [1:0] hit_tnew;
            logic       src_stall;
            logic [1:0] src_sel;

            // Walk W -> E so the nearest (E) match is the one that sticks.
            always_comb begin
                hit_stage = FWD_REG;
                hit_tnew  = 2'd0;
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (ura_hit(src_ura[gi], st_a[s], st_b[s])) begin
                        hit_stage = 2'(s + 1);
                        hit_tnew  = st_tnew[s];
                    end
                end
                src_stall = (hit_stage != FWD_REG) && (hit_tnew > src_tuse[gi]);
                src_sel   = ((hit_stage != FWD_REG) && (hit_tnew == 2'd0)) ? hit_stage : FWD_REG;
            end
        end
    endgenerate

    assign md_busy    = (md_cnt_q != 4'd0);
    assign stall      = d_valid && (g_src[0].src_stall || g_src[1].src_stall ||
                                    (d_uses_hilo && md_busy));
    assign fwd_rs_sel = g_src[0].src_sel;
    assign fwd_rt_sel = g_src[1].src_sel;

    assign md_load = e_load && ((d_md_kind == MD_MULT) || (d_md_kind == MD_DIV));

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_load) begin
            md_cnt_d = (d_md_kind == MD_MULT) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
        end else if (md_cnt_q != 4'd0) begin
            md_cnt_d = md_cnt_q - 4'd1;
        end
    end

    // The unit keeps running across a flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of single-cycle vectors that
// build pipeline state step by step, plus hand-written multi-cycle sequences.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       d_valid;
    logic [6:0] d_ura_real, d_ura_possible1, d_rs_ura, d_rt_ura;
    logic [1:0] d_tnew, d_rs_tuse, d_rt_tuse, d_md_kind;
    logic       d_uses_hilo, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [6:0] ura_real;
        logic [6:0] ura_p1;
        logic [1:0] tnew;
        logic [6:0] rs;
        logic [1:0] rs_tuse;
        logic [6:0] rt;
        logic [1:0] rt_tuse;
        logic [1:0] kind;
        logic       hilo;
        logic       flush;
        logic       e_stall;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       e_busy;
    } vec_t;

    vec_t vecs [13];

    hazard_scoreboard dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .d_valid        (d_valid),
        .d_ura_real     (d_ura_real),
        .d_ura_possible1(d_ura_possible1),
        .d_tnew         (d_tnew),
        .d_rs_ura       (d_rs_ura),
        .d_rs_tuse      (d_rs_tuse),
        .d_rt_ura       (d_rt_ura),
        .d_rt_tuse      (d_rt_tuse),
        .d_md_kind      (d_md_kind),
        .d_uses_hilo    (d_uses_hilo),
        .flush          (flush),
        .stall          (stall),
        .fwd_rs_sel     (fwd_rs_sel),
        .fwd_rt_sel     (fwd_rt_sel),
        .md_busy        (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "simulation time limit reached");
    end

    function automatic vec_t mkd(input logic valid, input logic [6:0] ura_real,
                                 input logic [6:0] ura_p1, input logic [1:0] tnew,
                                 input logic [6:0] rs, input logic [1:0] rs_tuse,
                                 input logic [6:0] rt, input logic [1:0] rt_tuse,
                                 input logic [1:0] kind, input logic hilo,
                                 input logic fl);
        vec_t v;
        v = '{valid, ura_real, ura_p1, tnew, rs, rs_tuse, rt, rt_tuse,
              kind, hilo, fl, 1'b0, 2'd0, 2'd0, 1'b0};
        return v;
    endfunction

    // Drive D-stage inputs on the falling edge, settle, then let the caller sample.
    task automatic apply(input vec_t v);
        @(negedge clk);
        d_valid         = v.valid;
        d_ura_real      = v.ura_real;
        d_ura_possible1 = v.ura_p1;
        d_tnew          = v.tnew;
        d_rs_ura        = v.rs;
        d_rs_tuse       = v.rs_tuse;
        d_rt_ura        = v.rt;
        d_rt_tuse       = v.rt_tuse;
        d_md_kind       = v.kind;
        d_uses_hilo     = v.hilo;
        flush           = v.flush;
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        d_valid = 1'b0; d_ura_real = '0; d_ura_possible1 = '0; d_tnew = '0;
        d_rs_ura = '0; d_rs_tuse = '0; d_rt_ura = '0; d_rt_tuse = '0;
        d_md_kind = MD_NONE; d_uses_hilo = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t v;

        // valid ura_real p1 tnew rs rs_tuse rt rt_tuse kind hilo flush | stall rs_sel rt_sel busy
        vecs[0]  = '{1, 0,  0, 0, 1,  0, 2,  0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1,  0, 2, 29, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 4,  0, 1, 1,  1, 3,  1, 0, 0, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 4,  0, 1, 1,  1, 3,  1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 5,  0, 0, 4,  1, 1,  1, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 31, 0, 0, 5,  0, 4,  0, 0, 0, 0, 0, 1, 2, 0};
        vecs[6]  = '{1, 31, 0, 0, 4,  0, 31, 0, 0, 0, 0, 0, 3, 1, 0};
        vecs[7]  = '{1, 0,  0, 0, 31, 0, 5,  0, 0, 0, 0, 0, 1, 3, 0};
        vecs[8]  = '{0, 9,  0, 2, 31, 0, 0,  0, 2, 1, 0, 0, 2, 0, 0};
        vecs[9]  = '{1, 6,  0, 2, 9,  0, 31, 0, 0, 1, 0, 0, 0, 3, 0};
        vecs[10] = '{1, 0,  0, 0, 0,  0, 6,  1, 0, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{1, 0,  0, 0, 0,  0, 6,  0, 0, 0, 0, 1, 0, 0, 0};
        vecs[12] = '{1, 0,  0, 0, 0,  0, 6,  1, 0, 0, 0, 0, 0, 0, 0};

        // ---- table-driven pipeline walk ----
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            $display("vec%0d stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                     i, stall, fwd_rs_sel, fwd_rt_sel, md_busy);
            chk($sformatf("vec%0d_stall", i), int'(stall), int'(vecs[i].e_stall));
            chk($sformatf("vec%0d_rs_sel", i), int'(fwd_rs_sel), int'(vecs[i].e_rs));
            chk($sformatf("vec%0d_rt_sel", i), int'(fwd_rt_sel), int'(vecs[i].e_rt));
            chk($sformatf("vec%0d_busy", i), int'(md_busy), int'(vecs[i].e_busy));
        end

        // ---- div: busy exactly DIV cycles, mflo stalls throughout ----
        do_reset();
        apply(mkd(1, URA_HI, URA_LO, 0, 1, 0, 2, 0, MD_DIV, 1, 0));
        chk("div_issue_stall", int'(stall), 0);
        chk("div_issue_busy", int'(md_busy), 0);
        v = mkd(1, 8, 0, 1, URA_LO, 0, 0, 0, MD_NONE, 1, 0);
        for (int i = 0; i < 10; i++) begin
            apply(v);
            $display("div wait %0d stall=%0d busy=%0d", i, stall, md_busy);
            chk($sformatf("div_wait%0d_stall", i), int'(stall), 1);
            chk($sformatf("div_wait%0d_busy", i), int'(md_busy), 1);
            if (i == 0) chk("div_wait_lo_sel", int'(fwd_rs_sel), int'(FWD_E));
        end
        apply(v);
        $display("div done stall=%0d busy=%0d", stall, md_busy);
        chk("div_done_stall", int'(stall), 0);
        chk("div_done_busy", int'(md_busy), 0);

        // ---- mult + mflo, then $0 and reserved kind ----
        do_reset();
        apply(mkd(1, URA_HI, URA_LO, 0, 1, 0, 2, 0, MD_MULT, 1, 0));
        chk("mult_issue_stall", int'(stall), 0);
        v = mkd(1, 9, 0, 1, URA_LO, 0, 0, 0, MD_NONE, 1, 0);
        for (int i = 0; i < 5; i++) begin
            apply(v);
            $display("mult wait %0d stall=%0d busy=%0d", i, stall, md_busy);
            chk($sformatf("mult_wait%0d_stall", i), int'(stall), 1);
        end
        apply(v);
        chk("mult_done_stall", int'(stall), 0);
        chk("mult_done_busy", int'(md_busy), 0);
        apply(mkd(1, 0, 0, 2, 0, 0, 0, 0, MD_RSVD, 0, 0));
        apply(mkd(1, 0, 0, 0, 0, 0, 0, 0, MD_NONE, 0, 0));
        $display("zero src stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                 stall, fwd_rs_sel, fwd_rt_sel, md_busy);
        chk("zero_stall", int'(stall), 0);
        chk("zero_rs_sel", int'(fwd_rs_sel), 0);
        chk("zero_rt_sel", int'(fwd_rt_sel), 0);
        chk("rsvd_kind_busy", int'(md_busy), 0);

        // ---- flush with stall asserted; md counter survives ----
        do_reset();
        apply(mkd(1, URA_HI, URA_LO, 0, 0, 0, 0, 0, MD_DIV, 1, 0));
        apply(mkd(1, 2, 0, 2, 0, 0, 0, 0, MD_NONE, 0, 0));
        apply(mkd(1, 3, 0, 0, 2, 0, 0, 0, MD_NONE, 0, 1));
        chk("flush_cycle_stall", int'(stall), 1);
        apply(mkd(1, 0, 0, 0, 2, 0, URA_LO, 0, MD_NONE, 0, 0));
        $display("after flush stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                 stall, fwd_rs_sel, fwd_rt_sel, md_busy);
        chk("post_flush_stall", int'(stall), 0);
        chk("post_flush_rs_sel", int'(fwd_rs_sel), 0);
        chk("post_flush_rt_sel", int'(fwd_rt_sel), 0);
        chk("post_flush_busy", int'(md_busy), 1);
        v = mkd(0, 0, 0, 0, 0, 0, 0, 0, MD_NONE, 0, 0);
        for (int i = 0; i < 7; i++) begin
            apply(v);
            chk($sformatf("flush_md_run%0d_busy", i), int'(md_busy), 1);
        end
        apply(v);
        chk("flush_md_end_busy", int'(md_busy), 0);

        // ---- reset in the middle of a div with a load-use stall pending ----
        do_reset();
        apply(mkd(1, URA_HI, URA_LO, 0, 0, 0, 0, 0, MD_DIV, 1, 0));
        apply(v);
        apply(v);
        apply(mkd(1, 3, 0, 2, 0, 0, 0, 0, MD_NONE, 0, 0));
        apply(mkd(1, URA_RA, 0, 0, 3, 0, 3, 0, MD_NONE, 1, 0));
        chk("pre_reset_stall", int'(stall), 1);
        chk("pre_reset_busy", int'(md_busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        $display("after mid reset stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                 stall, fwd_rs_sel, fwd_rt_sel, md_busy);
        chk("mid_reset_stall", int'(stall), 0);
        chk("mid_reset_busy", int'(md_busy), 0);
        chk("mid_reset_rs_sel", int'(fwd_rs_sel), 0);
        chk("mid_reset_rt_sel", int'(fwd_rt_sel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Decode-side hazard controller for the 5-stage MIPS pipeline.
- Consumes the unified register addresses (URA) produced by the destination decoder for the instruction in D, plus source URAs and Tuse values.
- Tracks in-flight destinations through E/M/W with Tnew countdowns and a mult/div busy counter.
- Emits a D-stage stall and per-source forwarding selects.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded for mult/multu.
- DIV_CYCLES, 10, busy cycles loaded for div/divu.
- URA_W, 7, URA width: 00xxxxx GRF, 01xxxxx CP0, 1000000 HI, 1000001 LO.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- d_valid  in  1  D holds a real instruction
- d_ura_real  in  7  primary destination URA of D instruction (0 = none)
- d_ura_possible1  in  7  secondary destination URA (LO for mult/div; 0 = none)
- d_tnew  in  2  cycles after entering E until result exists (0..2)
- d_rs_ura  in  7  source 1 URA (0 = unused)
- d_rs_tuse  in  2  cycles after D until source 1 consumed
- d_rt_ura  in  7  source 2 URA (0 = unused)
- d_rt_tuse  in  2  cycles after D until source 2 consumed
- d_md_kind  in  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as none)
- d_uses_hilo  in  1  D is mfhi/mflo/mthi/mtlo/mult/div
- flush  in  1  exception/eret; kill all in-flight tracking
- stall  out  1  hold PC and D, bubble into E
- fwd_rs_sel  out  2  0 GRF/CP0/HILO reg, 1 from E, 2 from M, 3 from W
- fwd_rt_sel  out  2  same encoding for source 2
- md_busy  out  1  mult/div counter nonzero

Behaviour:
- State per stage S in {E,M,W}: ura_a[S], ura_b[S] (7b), tnew[S] (2b); plus md_cnt (4b).
- Reset (reset_n=0 at clk edge): all ura/tnew/md_cnt = 0.
  - Outputs are combinational from state, so after reset: stall=0, fwd_*_sel=0, md_busy=0.
- URA 0 never matches and is never forwarded.
- Advance each edge:
  - W <= M.
  - M <= E with tnew decremented, saturating at 0.
  - E <= D fields when d_valid & !stall & !flush; otherwise E <= bubble (all 0).
- flush=1: E, M and W all cleared at the edge; flush wins over stall. md_cnt is not cleared (unit keeps running).
- Match for source X:
  - Nearest stage (priority E > M > W) where X != 0 and X equals ura_a or ura_b of that stage.
  - Only the nearest match is considered.
- stall conditions, any of:
  - (a) nearest match for rs has tnew[S] > d_rs_tuse;
  - (b) same for rt;
  - (c) d_valid & d_uses_hilo & md_busy.
  - stall is gated by d_valid.
- fwd_X_sel:
  - stage code of the nearest match if its tnew == 0;
  - else 0. The value is don't-care while stall=1 but must still follow this rule.
- md_cnt:
  - Loaded with MULT_CYCLES or DIV_CYCLES at the edge where a d_md_kind 01/10 instruction enters E (d_valid & !stall & !flush).
  - Otherwise decrements while nonzero.
  - Load overrides decrement.
  - md_busy = (md_cnt != 0).
- Latency: stall and selects are same-cycle combinational. No path from stall to its own inputs, so no combinational loop.
- Reset mid-operation: next cycle is identical to the post-reset state regardless of md_cnt.

Decomposition:
- Shared package/macros:
  - URA constants: URA_NONE=0, URA_HI=7'b1000000, URA_LO=7'b1000001, URA_RA=7'b0011111.
  - FWD_* select codes.
  - MD_KIND encodings.
- One natural sub-module: hazard_stage_reg (one E/M/W slot with bubble/flush/tnew-decrement), instantiated 3x.

Test Plan:
- lw $1 in E (tnew=2), D addu reading $1 with rs_tuse=1 -> stall=1 one cycle. Next cycle M has tnew=1 -> stall=0 if tuse=1, fwd_rs_sel=2 once tnew=0.
- jal in E (d_tnew=0, URA 7'h1f), D jr $ra tuse=0 -> stall=0, fwd_rs_sel=1. Same URA also in M -> still 1 (E priority).
- div enters E -> md_busy=1 for exactly 10 cycles. mflo in D during them -> stall=1 each cycle; stall drops on the cycle md_busy falls.
- mult enters E with secondary URA LO, then mflo (rs_ura=7'h41) -> stalled by md_busy. Register $0 destination with source $0 -> never stall, sel=0.
- flush with lw $2 in E and stall asserted -> next cycle all stages empty, stall=0, sel=0. md_cnt continues counting.
- reset_n=0 during div busy (md_cnt=7) -> next cycle md_busy=0, stall=0, all selects 0.
